// File: rtl/rxd_link_pkg.sv
// Shared encodings and constants for the rxd link supervisor.
package rxd_link_pkg;

   localparam int TMR_W = 20;

   typedef enum logic [1:0] {
      ST_RESET  = 2'd0,
      ST_ACQ    = 2'd1,
      ST_LOCKED = 2'd2,
      ST_FAULT  = 2'd3
   } link_state_e;

   typedef enum logic [1:0] {
      FC_NONE = 2'd0,
      FC_BRK  = 2'd1,
      FC_PERR = 2'd2,
      FC_TOUT = 2'd3
   } fault_code_e;

   // The timer starts at 0 on state entry, so a duration of N cycles ends at N-1.
   function automatic logic [TMR_W-1:0] tmr_tc(input int cycles);
      return TMR_W'(cycles - 1);
   endfunction

endpackage

// File: rtl/rxd_link_qual.sv
// Consecutive-condition counter: counts inc_i cycles, clr_i restarts it,
// hit_o flags the increment that reaches THRESH.
module rxd_link_qual #(
   parameter int THRESH = 8,
   parameter int CNT_W  = $clog2(THRESH + 1)
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic clr_i,
   input  logic inc_i,
   output logic hit_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != CNT_W'(THRESH))) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign hit_o = inc_i && !clr_i && (cnt_q == CNT_W'(THRESH - 1));

endmodule

// File: rtl/rxd_link_ctrl.sv
// Bring-up / supervision sequencer for one rxd detector channel.
// Optional fault counter enabled by defining RXD_LINK_FAULT_CNT_EN.
//
// state     | meaning
// ST_RESET  | detector held in re-arm (det_clr_n low) for CLR_CYC cycles
// ST_ACQ    | waiting for LOCK_CONFIRM clean lock cycles, bounded by ACQ_TIMEOUT
// ST_LOCKED | link up, supervising brk / pulse_err / lock_stat
// ST_FAULT  | holdoff before retry, or parked once the retry budget is spent
module rxd_link_ctrl
   import rxd_link_pkg::*;
#(
   parameter int CLR_CYC      = 20,
   parameter int LOCK_CONFIRM = 2000,
   parameter int ACQ_TIMEOUT  = 400000,
   parameter int ERR_TOL      = 200,
   parameter int HOLDOFF      = 20000,
   parameter int MAX_RETRY    = 3
) (
   input  logic       clk_20M,
   input  logic       clr,
   input  logic       lock_stat,
   input  logic       pulse_err,
   input  logic       phaselock_brk,
   input  logic       fault_ack,
   output logic       det_clr_n,
   output logic       link_ok,
   output logic [1:0] link_state,
   output logic [1:0] fault_code,
   output logic       fault_latched,
   output logic [7:0] fault_cnt
);

   localparam int RTRY_W = 8;

   link_state_e        state_q, state_d;
   fault_code_e        code_q, code_d;
   logic [TMR_W-1:0]   tmr_q, tmr_d;
   logic [RTRY_W-1:0]  retry_q, retry_d;
   logic               latched_q, latched_d;
   logic               det_clr_n_q;
   logic               link_ok_q;
   logic               fault_ev;
   logic               clean_lock;
   logic               conf_hit;
   logic               err_hit;

   assign clean_lock = lock_stat && !pulse_err && !phaselock_brk;

   rxd_link_qual #(.THRESH(LOCK_CONFIRM)) u_confirm (
      .clk_i   (clk_20M),
      .rst_n_i (clr),
      .clr_i   ((state_q != ST_ACQ) || !clean_lock),
      .inc_i   ((state_q == ST_ACQ) && clean_lock),
      .hit_o   (conf_hit)
   );

   rxd_link_qual #(.THRESH(ERR_TOL)) u_err_tol (
      .clk_i   (clk_20M),
      .rst_n_i (clr),
      .clr_i   ((state_q != ST_LOCKED) || !pulse_err),
      .inc_i   ((state_q == ST_LOCKED) && pulse_err),
      .hit_o   (err_hit)
   );

   always_comb begin
      state_d   = state_q;
      code_d    = code_q;
      retry_d   = retry_q;
      latched_d = latched_q;
      fault_ev  = 1'b0;

      case (state_q)
         ST_RESET: begin
            if (tmr_q == tmr_tc(CLR_CYC)) state_d = ST_ACQ;
         end
         ST_ACQ: begin
            if (phaselock_brk) begin
               state_d  = ST_FAULT;
               code_d   = FC_BRK;
               fault_ev = 1'b1;
            end else if (tmr_q == tmr_tc(ACQ_TIMEOUT)) begin
               state_d  = ST_FAULT;
               code_d   = FC_TOUT;
               fault_ev = 1'b1;
            end else if (conf_hit) begin
               state_d  = ST_LOCKED;
               retry_d  = '0;
            end
         end
         ST_LOCKED: begin
            if (phaselock_brk) begin
               state_d  = ST_FAULT;
               code_d   = FC_BRK;
               fault_ev = 1'b1;
            end else if (err_hit) begin
               state_d  = ST_FAULT;
               code_d   = FC_PERR;
               fault_ev = 1'b1;
            end else if (!lock_stat) begin
               state_d  = ST_FAULT;
               code_d   = FC_TOUT;
               fault_ev = 1'b1;
            end
         end
         ST_FAULT: begin
            if (fault_ack) begin
               state_d   = ST_RESET;
               code_d    = FC_NONE;
               retry_d   = '0;
               latched_d = 1'b0;
            end else if (!latched_q && (tmr_q == tmr_tc(HOLDOFF))) begin
               state_d = ST_RESET;
            end
         end
         default: state_d = ST_RESET;
      endcase

      // A fault on the same edge as an ack takes precedence; the ack is dropped.
      if (fault_ev) begin
         retry_d = retry_q + RTRY_W'(1);
         if (retry_d == RTRY_W'(MAX_RETRY)) latched_d = 1'b1;
      end else if (fault_ack && (state_q != ST_FAULT)) begin
         code_d = FC_NONE;
      end

      if (state_d != state_q) begin
         tmr_d = '0;
      end else if (tmr_q != '1) begin
         tmr_d = tmr_q + TMR_W'(1);
      end else begin
         tmr_d = tmr_q;
      end
   end

   always_ff @(posedge clk_20M or negedge clr) begin
      if (!clr) begin
         state_q     <= ST_RESET;
         code_q      <= FC_NONE;
         tmr_q       <= '0;
         retry_q     <= '0;
         latched_q   <= 1'b0;
         det_clr_n_q <= 1'b0;
         link_ok_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         code_q      <= code_d;
         tmr_q       <= tmr_d;
         retry_q     <= retry_d;
         latched_q   <= latched_d;
         det_clr_n_q <= (state_d != ST_RESET);
         link_ok_q   <= (state_d == ST_LOCKED);
      end
   end

`ifdef RXD_LINK_FAULT_CNT_EN
   logic [7:0] fcnt_q;

   always_ff @(posedge clk_20M or negedge clr) begin
      if (!clr) begin
         fcnt_q <= '0;
      end else if (fault_ev && (fcnt_q != 8'hFF)) begin
         fcnt_q <= fcnt_q + 8'd1;
      end
   end

   assign fault_cnt = fcnt_q;
`else
   assign fault_cnt = 8'd0;
`endif

   assign det_clr_n     = det_clr_n_q;
   assign link_ok       = link_ok_q;
   assign link_state    = state_q;
   assign fault_code    = code_q;
   assign fault_latched = latched_q;

endmodule
